// File: rtl/wb_stage.sv
// ============================================================================
// wb_stage : MangoMIPS32 write-back stage (load align, result select, GPR
//            write port, HI/LO and LLbit state, retire trace)
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_stage #(
   parameter logic [63:0] HILO_RST  = 64'h0,
   parameter bit          HAS_LLBIT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wb_pc,
   input  logic [5:0]  wb_aluop,
   input  logic [31:0] wb_alures,
   input  logic [31:0] wb_mulres,
   input  logic [31:0] wb_m_vaddr,
   input  logic [31:0] wb_m_rdata,
   input  logic [3:0]  wb_wreg,
   input  logic [4:0]  wb_wraddr,
   input  logic        wb_hilo_wen,
   input  logic [63:0] wb_hilo,
   input  logic        wb_llb_wen,
   input  logic        wb_llbit,
   input  logic        llb_clr,
   output logic [3:0]  rf_wen,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        llbit_o,
   output logic [31:0] trace_pc,
   output logic [3:0]  trace_wen,
   output logic [4:0]  trace_waddr,
   output logic [31:0] trace_wdata
);

   // Operation codes shared with the decode stage.
   localparam logic [5:0] ALU_LB  = 6'h10;
   localparam logic [5:0] ALU_LBU = 6'h11;
   localparam logic [5:0] ALU_LH  = 6'h12;
   localparam logic [5:0] ALU_LHU = 6'h13;
   localparam logic [5:0] ALU_LW  = 6'h14;
   localparam logic [5:0] ALU_LWL = 6'h15;
   localparam logic [5:0] ALU_LWR = 6'h16;
   localparam logic [5:0] ALU_LL  = 6'h17;
   localparam logic [5:0] ALU_MUL = 6'h20;
   localparam logic [5:0] ALU_SC  = 6'h21;

   logic [1:0]  off;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;
   logic        is_load;
   logic [63:0] hilo_q;
   logic        llbit_q;

   assign off      = wb_m_vaddr[1:0];
   assign byte_sel = 8'(wb_m_rdata >> {off, 3'b000});
   assign half_sel = off[1] ? wb_m_rdata[31:16] : wb_m_rdata[15:0];

   always_comb begin
      load_data = wb_m_rdata;
      is_load   = 1'b1;
      case (wb_aluop)
         ALU_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
         ALU_LBU: load_data = {24'h0, byte_sel};
         ALU_LH:  load_data = {{16{half_sel[15]}}, half_sel};
         ALU_LHU: load_data = {16'h0, half_sel};
         ALU_LW:  load_data = wb_m_rdata;
         ALU_LL:  load_data = wb_m_rdata;
         // Partial-word loads only shift; byte merging comes from wb_wreg.
         ALU_LWL: load_data = wb_m_rdata << {2'd3 - off, 3'b000};
         ALU_LWR: load_data = wb_m_rdata >> {off, 3'b000};
         default: is_load   = 1'b0;
      endcase
   end

   always_comb begin
      if (is_load)
         rf_wdata = load_data;
      else if (wb_aluop == ALU_MUL)
         rf_wdata = wb_mulres;
      else if (wb_aluop == ALU_SC)
         rf_wdata = {31'h0, llbit_q};
      else
         rf_wdata = wb_alures;
   end

   assign rf_wen   = (wb_wraddr == 5'd0) ? 4'h0 : wb_wreg;
   assign rf_waddr = wb_wraddr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         hilo_q <= HILO_RST;
      else if (wb_hilo_wen)
         hilo_q <= wb_hilo;
   end

   assign {hi_o, lo_o} = wb_hilo_wen ? wb_hilo : hilo_q;

   generate
      if (HAS_LLBIT) begin : g_llbit
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               llbit_q <= 1'b0;
            else if (llb_clr)
               llbit_q <= 1'b0;
            else if (wb_llb_wen)
               llbit_q <= wb_llbit;
         end
      end else begin : g_no_llbit
         assign llbit_q = 1'b0;
      end
   endgenerate

   assign llbit_o = llbit_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         trace_pc    <= 32'h0;
         trace_wen   <= 4'h0;
         trace_waddr <= 5'h0;
         trace_wdata <= 32'h0;
      end else if (|rf_wen) begin
         trace_pc    <= wb_pc;
         trace_wen   <= rf_wen;
         trace_waddr <= rf_waddr;
         trace_wdata <= rf_wdata;
      end else begin
         trace_wen   <= 4'h0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// tb_wb_stage : directed plus randomized checks of wb_stage against a
//               byte-level behavioural model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_wb_stage;

   localparam logic [63:0] HILO_RST = 64'hDEAD_BEEF_0123_4567;

   localparam logic [5:0] OP_ADD = 6'h01;
   localparam logic [5:0] OP_LB  = 6'h10;
   localparam logic [5:0] OP_LBU = 6'h11;
   localparam logic [5:0] OP_LH  = 6'h12;
   localparam logic [5:0] OP_LHU = 6'h13;
   localparam logic [5:0] OP_LW  = 6'h14;
   localparam logic [5:0] OP_LWL = 6'h15;
   localparam logic [5:0] OP_LWR = 6'h16;
   localparam logic [5:0] OP_LL  = 6'h17;
   localparam logic [5:0] OP_MUL = 6'h20;
   localparam logic [5:0] OP_SC  = 6'h21;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wb_pc, wb_alures, wb_mulres, wb_m_vaddr, wb_m_rdata;
   logic [5:0]  wb_aluop;
   logic [3:0]  wb_wreg;
   logic [4:0]  wb_wraddr;
   logic        wb_hilo_wen, wb_llb_wen, wb_llbit, llb_clr;
   logic [63:0] wb_hilo;
   logic [3:0]  rf_wen, trace_wen;
   logic [4:0]  rf_waddr, trace_waddr;
   logic [31:0] rf_wdata, hi_o, lo_o, trace_pc, trace_wdata;
   logic        llbit_o;

   int n_checks = 0;
   int n_pass   = 0;

   // Architectural model state
   logic [63:0] m_hilo;
   logic        m_ll;
   logic [31:0] m_tpc, m_twdata;
   logic [3:0]  m_twen;
   logic [4:0]  m_twaddr;

   logic [5:0] op_pool [11] = '{OP_ADD, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
                               OP_LWL, OP_LWR, OP_LL, OP_MUL, OP_SC};

   wb_stage #(.HILO_RST(HILO_RST), .HAS_LLBIT(1'b1)) dut (
      .clk(clk), .rst(rst), .wb_pc(wb_pc), .wb_aluop(wb_aluop),
      .wb_alures(wb_alures), .wb_mulres(wb_mulres), .wb_m_vaddr(wb_m_vaddr),
      .wb_m_rdata(wb_m_rdata), .wb_wreg(wb_wreg), .wb_wraddr(wb_wraddr),
      .wb_hilo_wen(wb_hilo_wen), .wb_hilo(wb_hilo), .wb_llb_wen(wb_llb_wen),
      .wb_llbit(wb_llbit), .llb_clr(llb_clr), .rf_wen(rf_wen),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hi_o(hi_o), .lo_o(lo_o),
      .llbit_o(llbit_o), .trace_pc(trace_pc), .trace_wen(trace_wen),
      .trace_waddr(trace_waddr), .trace_wdata(trace_wdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] model_load(input logic [5:0] op, input logic [1:0] a,
                                              input logic [31:0] w);
      logic [7:0]  b [4];
      logic [31:0] r;
      logic [15:0] h;
      int o;
      o = int'(a);
      for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
      h = {b[2*(o/2)+1], b[2*(o/2)]};
      r = 32'h0;
      case (op)
         OP_LB:  r = (b[o] >= 8'd128) ? (32'hFFFF_FF00 | 32'(b[o])) : 32'(b[o]);
         OP_LBU: r = 32'(b[o]);
         OP_LH:  r = (h >= 16'h8000) ? (32'hFFFF_0000 | 32'(h)) : 32'(h);
         OP_LHU: r = 32'(h);
         OP_LWL: for (int j = 0; j < 4; j++) if (j >= 3 - o) r[8*j +: 8] = b[j - (3 - o)];
         OP_LWR: for (int j = 0; j < 4; j++) if (j + o <= 3) r[8*j +: 8] = b[j + o];
         default: r = w;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] exp_wdata();
      case (wb_aluop)
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_LL:
            return model_load(wb_aluop, wb_m_vaddr[1:0], wb_m_rdata);
         OP_MUL:  return wb_mulres;
         OP_SC:   return {31'h0, m_ll};
         default: return wb_alures;
      endcase
   endfunction

   function automatic logic [3:0] exp_wen();
      return (wb_wraddr == 5'd0) ? 4'h0 : wb_wreg;
   endfunction

   task automatic idle();
      wb_pc = 32'h0; wb_aluop = OP_ADD; wb_alures = 32'h0; wb_mulres = 32'h0;
      wb_m_vaddr = 32'h0; wb_m_rdata = 32'h0; wb_wreg = 4'h0; wb_wraddr = 5'd0;
      wb_hilo_wen = 1'b0; wb_hilo = 64'h0; wb_llb_wen = 1'b0; wb_llbit = 1'b0;
      llb_clr = 1'b0;
   endtask

   task automatic model_reset();
      m_hilo = HILO_RST; m_ll = 1'b0;
      m_tpc = 32'h0; m_twen = 4'h0; m_twaddr = 5'h0; m_twdata = 32'h0;
   endtask

   // Clock edge with model update from the inputs held across it.
   task automatic tick();
      logic [3:0]  e_wen;
      logic [31:0] e_wd;
      e_wen = exp_wen();
      e_wd  = exp_wdata();
      @(posedge clk);
      if (wb_hilo_wen) m_hilo = wb_hilo;
      if (llb_clr) m_ll = 1'b0;
      else if (wb_llb_wen) m_ll = wb_llbit;
      if (e_wen != 4'h0) begin
         m_tpc = wb_pc; m_twen = e_wen; m_twaddr = wb_wraddr; m_twdata = e_wd;
      end else begin
         m_twen = 4'h0;
      end
      #1;
   endtask

   task automatic check_all(input string tag);
      logic [63:0] hl;
      hl = wb_hilo_wen ? wb_hilo : m_hilo;
      check({tag, ".rf_wen"},   64'(rf_wen),   64'(exp_wen()));
      check({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(wb_wraddr));
      check({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(exp_wdata()));
      check({tag, ".hilo"},     {hi_o, lo_o},  hl);
      check({tag, ".llbit"},    64'(llbit_o),  64'(m_ll));
      check({tag, ".trace"},    {trace_pc, 15'h0, trace_wen, trace_waddr},
                                {m_tpc, 15'h0, m_twen, m_twaddr});
      check({tag, ".trace_wd"}, 64'(trace_wdata), 64'(m_twdata));
   endtask

   initial begin
      idle();
      rst = 1'b0;
      model_reset();
      #12;
      check("reset.hilo",  {hi_o, lo_o}, HILO_RST);
      check("reset.llbit", 64'(llbit_o), 64'h0);
      check("reset.trace", {trace_pc, trace_wdata}, 64'h0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Byte / half / partial-word loads
      wb_wraddr = 5'd5; wb_wreg = 4'hF; wb_pc = 32'hBFC0_0000;
      wb_aluop = OP_LB; wb_m_vaddr = 32'h1000_0002; wb_m_rdata = 32'h80FF_7F01; #1;
      check("lb", 64'(rf_wdata), 64'hFFFF_FFFF);
      wb_aluop = OP_LBU; #1;
      check("lbu", 64'(rf_wdata), 64'h0000_00FF);
      wb_aluop = OP_LH; wb_m_rdata = 32'h8001_1234; #1;
      check("lh", 64'(rf_wdata), 64'hFFFF_8001);
      wb_aluop = OP_LWL; wb_m_vaddr = 32'h1000_0001; wb_m_rdata = 32'hAABB_CCDD; #1;
      check("lwl", 64'(rf_wdata), 64'hCCDD_0000);
      wb_aluop = OP_LWR; #1;
      check("lwr", 64'(rf_wdata), 64'h00AA_BBCC);
      tick();
      check("trace_lwr", {28'h0, trace_wen, trace_wdata}, {28'h0, 4'hF, 32'h00AA_BBCC});

      // Writes to $0 are suppressed and do not retire
      wb_wraddr = 5'd0; wb_aluop = OP_ADD; wb_alures = 32'h1234_5678; #1;
      check("r0.rf_wen", 64'(rf_wen), 64'h0);
      tick();
      check("r0.trace_wen", 64'(trace_wen), 64'h0);

      // HI/LO same-cycle bypass, then hold
      idle();
      wb_hilo_wen = 1'b1; wb_hilo = 64'h0000_0001_0000_0002; #1;
      check("hilo.bypass", {hi_o, lo_o}, 64'h0000_0001_0000_0002);
      tick();
      wb_hilo_wen = 1'b0; wb_hilo = 64'hFFFF_FFFF_FFFF_FFFF; #1;
      check("hilo.hold", {hi_o, lo_o}, 64'h0000_0001_0000_0002);

      // LL / SC and clear priority
      idle();
      wb_aluop = OP_LL; wb_llb_wen = 1'b1; wb_llbit = 1'b1; wb_wraddr = 5'd2; wb_wreg = 4'hF;
      tick();
      check("ll.llbit", 64'(llbit_o), 64'h1);
      idle();
      wb_aluop = OP_SC; wb_wraddr = 5'd3; wb_wreg = 4'hF; wb_alures = 32'hFFFF_FFF0; #1;
      check("sc.one", 64'(rf_wdata), 64'h1);
      idle();
      wb_llb_wen = 1'b1; wb_llbit = 1'b1; llb_clr = 1'b1;
      tick();
      check("clr.priority", 64'(llbit_o), 64'h0);
      idle();
      wb_aluop = OP_SC; wb_wraddr = 5'd3; wb_wreg = 4'hF; #1;
      check("sc.zero", 64'(rf_wdata), 64'h0);
      tick();

      // Randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         wb_pc       = $urandom;
         wb_aluop    = op_pool[$urandom_range(0, 10)];
         wb_alures   = $urandom;
         wb_mulres   = $urandom;
         wb_m_vaddr  = $urandom;
         wb_m_rdata  = $urandom;
         wb_wreg     = 4'($urandom);
         wb_wraddr   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
         wb_hilo_wen = ($urandom_range(0, 3) == 0);
         wb_hilo     = {$urandom, $urandom};
         wb_llb_wen  = ($urandom_range(0, 2) == 0);
         wb_llbit    = 1'($urandom);
         llb_clr     = ($urandom_range(0, 7) == 0);
         #1;
         check_all($sformatf("rnd%0d", i));
         tick();
      end

      // Asynchronous reset mid-stream with a pending HI/LO write
      idle();
      wb_hilo_wen = 1'b1; wb_hilo = 64'h1111_2222_3333_4444;
      wb_llb_wen = 1'b1; wb_llbit = 1'b1; wb_wraddr = 5'd7; wb_wreg = 4'hF;
      tick();
      #1 rst = 1'b0;
      model_reset();
      #1;
      wb_hilo_wen = 1'b0; #1;
      check("arst.hilo",  {hi_o, lo_o}, HILO_RST);
      check("arst.llbit", 64'(llbit_o), 64'h0);
      check("arst.trace", {trace_pc, 15'h0, trace_wen, trace_waddr}, 64'h0);
      check("arst.trace_wd", 64'(trace_wdata), 64'h0);
      rst = 1'b1;
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
